// File: rtl/seg_pkg.sv
// seg_pkg: active-low 7-segment codes {a,b,c,d,e,f,g} shared by the scan controller and decoder
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_CODE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low 7-segment code
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_CODE[hex];

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed 8-digit hex display scanner; define LEADING_ZERO_BLANK_EN to blank leading zeros
module digit_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  blank_mask,
  output logic [2:0]  sel,
  output logic [6:0]  seg,
  output logic        tick
);

  localparam int             CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST     = CW'(CLK_DIV - 1);
  localparam logic [2:0]     SEL_LAST = 3'(DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   sh_data, data_nxt;
  logic [7:0]    sh_mask, mask_nxt;
  logic          first, adv, wrap, blank;
  logic [2:0]    sel_nxt;
  logic [3:0]    nib;
  logic [6:0]    code;
`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0]    hi;
`endif

  // next digit and next shadow are computed ahead so seg is registered in step with sel
  always_comb begin
    adv      = en && cnt == LAST;
    wrap     = adv && sel >= SEL_LAST;
    sel_nxt  = wrap ? 3'd0 : adv ? sel + 3'd1 : sel;
    data_nxt = (first || wrap) ? data : sh_data;
    mask_nxt = (first || wrap) ? blank_mask : sh_mask;
    nib      = data_nxt[4*sel_nxt +: 4];
    blank    = mask_nxt[sel_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    hi = 3'd0;
    for (int i = 0; i < DIGITS; i++) hi = data_nxt[4*i +: 4] != 4'h0 ? 3'(i) : hi;
    blank = blank || sel_nxt > hi;
`endif
  end

  hex7seg u_hex (
    .hex(nib),
    .seg(code)
  );

  // prescaler, digit counter, frame shadow and registered segment output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      sel     <= '0;
      tick    <= 1'b0;
      seg     <= SEG_BLANK;
      sh_data <= '0;
      sh_mask <= '0;
      first   <= 1'b1;
    end else begin
      cnt     <= en ? (cnt == LAST ? '0 : cnt + CW'(1)) : cnt;
      sel     <= sel_nxt;
      tick    <= adv;
      seg     <= blank ? SEG_BLANK : code;
      sh_data <= data_nxt;
      sh_mask <= mask_nxt;
      first   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: self-checking bench for digit_scan_ctrl (honours LEADING_ZERO_BLANK_EN)
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  blank_mask = '0;
  logic [2:0]  sel_a, sel_b;
  logic [6:0]  seg_a, seg_b;
  logic        tick_a, tick_b;
  int          checks = 0;
  int          errors = 0;

  logic [6:0] code_of [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef struct {
    int          cnt;
    int          sel;
    bit          tick;
    logic [6:0]  seg;
    logic [31:0] sd;
    logic [7:0]  sm;
    bit          first;
  } mst_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       tick;
  } obs_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] code;
  } vec_t;

  mst_t ma, mb;
  obs_t qa[$], qb[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  digit_scan_ctrl #(.CLK_DIV(4), .DIGITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .blank_mask(blank_mask),
    .sel(sel_a), .seg(seg_a), .tick(tick_a)
  );

  digit_scan_ctrl #(.CLK_DIV(4), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .blank_mask(blank_mask),
    .sel(sel_b), .seg(seg_b), .tick(tick_b)
  );

  function automatic logic [6:0] expseg(logic [31:0] d, logic [7:0] m, int s, int nd);
    int hi = 0;
    if (m[s]) return 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < nd; i++) if (d[4*i +: 4] != 4'h0) hi = i;
    if (s > hi) return 7'h7F;
`endif
    return code_of[d[4*s +: 4]];
  endfunction

  function automatic mst_t mstep(mst_t s, int nd, bit rn, bit e, logic [31:0] d, logic [7:0] m);
    mst_t n = s;
    bit adv;
    if (!rn) begin
      n.cnt = 0; n.sel = 0; n.tick = 0; n.seg = 7'h7F; n.sd = '0; n.sm = '0; n.first = 1;
      return n;
    end
    adv    = e && s.cnt == 3;
    n.tick = adv;
    n.cnt  = e ? (s.cnt + 1) % 4 : s.cnt;
    n.sel  = adv ? (s.sel + 1) % nd : s.sel;
    if (s.first || (adv && n.sel == 0)) begin
      n.sd = d;
      n.sm = m;
    end
    n.first = 0;
    n.seg   = expseg(n.sd, n.sm, n.sel, nd);
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    obs_t ea, eb;
    ma = mstep(ma, 8, rst_n, en, data, blank_mask);
    mb = mstep(mb, 3, rst_n, en, data, blank_mask);
    qa.push_back({3'(ma.sel), ma.seg, ma.tick});
    qb.push_back({3'(mb.sel), mb.seg, mb.tick});
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("model_a", 32'({sel_a, seg_a, tick_a}), 32'(ea));
    chk("model_b", 32'({sel_b, seg_b, tick_b}), 32'(eb));
  endtask

  task automatic wait_a(int t);
    int k = 0;
    while (sel_a != 3'(t) && k < 64) begin
      cyc();
      k++;
    end
    chk("wait_sel_a", 32'(sel_a), 32'(t));
  endtask

  task automatic wait_b(int t);
    int k = 0;
    while (sel_b != 3'(t) && k < 64) begin
      cyc();
      k++;
    end
    chk("wait_sel_b", 32'(sel_b), 32'(t));
  endtask

  initial begin
    int k;
    logic [6:0] held;
    for (int i = 0; i < 16; i++) tbl[i] = '{nib: 4'(i), code: code_of[i]};

    // reset held for three cycles
    repeat (3) begin
      cyc();
      chk("rst_sel", 32'(sel_a), 0);
      chk("rst_seg", 32'(seg_a), 32'h7F);
      chk("rst_tick", 32'(tick_a), 0);
    end

    // every hex code shown on digit 0 right after reset release
    for (int i = 0; i < 16; i++) begin
      data  = {8{tbl[i].nib}};
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("hex_code", 32'(seg_a), 32'(tbl[i].code));
    end

    // scan a full frame
    data  = 32'h76543210;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    en    = 1'b1;
    cyc();
    chk("scan_sel0", 32'(sel_a), 0);
    chk("scan_seg0", 32'(seg_a), 32'h01);
    wait_a(1);
    chk("scan_seg1", 32'(seg_a), 32'h4F);
    chk("scan_tick", 32'(tick_a), 1);
    wait_a(2);
    k = 0;
    while (sel_a == 3'd2 && k < 16) begin
      cyc();
      k++;
    end
    chk("slot_len", 32'(k), 4);

    // mid-frame data change stays hidden until the next frame
    wait_a(3);
    data = 32'hFFFFFFFF;
    for (int d = 4; d < 8; d++) begin
      wait_a(d);
      chk("shadow_old", 32'(seg_a), 32'(code_of[d]));
    end
    wait_a(0);
    chk("shadow_new", 32'(seg_a), 32'h38);

    // enable hold at sel=5
    wait_a(5);
    cyc();
    held = seg_a;
    en = 1'b0;
    repeat (10) begin
      cyc();
      chk("hold_sel", 32'(sel_a), 5);
      chk("hold_tick", 32'(tick_a), 0);
      chk("hold_seg", 32'(seg_a), 32'(held));
    end
    en = 1'b1;
    k = 0;
    while (sel_a == 3'd5 && k < 16) begin
      cyc();
      k++;
    end
    chk("resume_len", 32'(k), 3);

    // short frame with digit 1 masked
    blank_mask = 8'h02;
    wait_b(2);
    wait_b(0);
    wait_b(1);
    chk("short_blank", 32'(seg_b), 32'h7F);
    wait_b(2);
    wait_b(0);
    wait_b(1);
    blank_mask = 8'h00;

    // leading-zero blanking
    data = 32'h000000A0;
    wait_a(7);
    wait_a(0);
    chk("lz_seg0", 32'(seg_a), 32'h01);
    wait_a(1);
    chk("lz_seg1", 32'(seg_a), 32'h08);
    wait_a(2);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_seg2", 32'(seg_a), 32'h7F);
`else
    chk("lz_seg2", 32'(seg_a), 32'h01);
`endif
    wait_a(5);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_seg5", 32'(seg_a), 32'h7F);
`else
    chk("lz_seg5", 32'(seg_a), 32'h01);
`endif

    // reset mid-frame with scanning disabled
    wait_a(3);
    en    = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk("midrst_sel", 32'(sel_a), 0);
    chk("midrst_seg", 32'(seg_a), 32'h7F);
    chk("midrst_tick", 32'(tick_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving clocks per digit slot; legal range 2..2^20.
REQ-002 The block SHALL have parameter DIGITS, default 8, giving the number of active digits; legal range 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: scan enable.
REQ-006 The block SHALL have port data, input, 32 bits: eight hex nibbles; nibble i (data[4i+3:4i]) is shown on digit i.
REQ-007 The block SHALL have port blank_mask, input, 8 bits: bit i = 1 forces digit i blank.
REQ-008 The block SHALL have port sel, output, 3 bits: digit index, wired directly to the 3-to-8 decoder inputs {I2,I1,I0}.
REQ-009 The block SHALL have port seg, output, 7 bits: active-low segments ordered {a,b,c,d,e,f,g}, with a as the MSB.
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each digit advance.

Function
REQ-011 The prescaler SHALL count 0..CLK_DIV-1 while en=1 and wrap to 0.
REQ-012 tick SHALL be 1 for exactly the cycle after the prescaler reaches CLK_DIV-1.
REQ-013 sel SHALL increment in that same cycle, wrapping from DIGITS-1 to 0.
REQ-014 With en=0, prescaler and sel SHALL hold, tick SHALL be 0, and seg SHALL keep showing the current digit; on en=1, counting resumes from the held value.
REQ-015 data and blank_mask SHALL be captured into a shadow register only on the cycle sel wraps to 0 and on the first cycle after reset is released.
REQ-016 Mid-frame input changes SHALL NOT be visible until the next frame.
REQ-017 seg SHALL be registered and SHALL always correspond to the sel value present in the same cycle, with no skew between sel and seg.
REQ-018 Hex to 7-segment encoding SHALL be 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04 A=08 b=60 C=31 d=42 E=30 F=38 (hex, active-low).
REQ-019 A blanked digit SHALL output seg=7'h7F.
REQ-020 An out-of-range sel value cannot occur; if it does, sel SHALL recover to 0 on the next tick.

Reset
REQ-021 While rst_n=0 at a clock edge: sel=0, prescaler=0, tick=0, seg=7'h7F, shadow=0.
REQ-022 Reset asserted mid-frame SHALL take effect at the next edge regardless of en.
REQ-023 No output SHALL change asynchronously.

Configuration
REQ-024 The macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-025 With LEADING_ZERO_BLANK_EN defined, every digit index above the highest nonzero shadow nibble among digits 0..DIGITS-1 SHALL be blanked; digit 0 is never blanked by this rule; blank_mask still applies on top.
REQ-026 Without LEADING_ZERO_BLANK_EN, only blank_mask SHALL blank digits.

Structure
REQ-027 Segment code constants and the blank code 7'h7F SHALL live in the shared package seg_pkg.
REQ-028 The hex-to-segment lookup SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out).
REQ-029 Prescaler, sel counter, shadow register and blanking logic SHALL reside in digit_scan_ctrl.

Verification
REQ-030 Reset: rst_n=0 for 3 cycles -> sel=0, seg=7F, tick=0 throughout.
REQ-031 Scan, CLK_DIV=4, DIGITS=8, data=32'h76543210, en=1 -> sel steps 0..7 every 4 cycles then 0; seg=01 at sel=0, 4F at sel=1, 0F at sel=7; tick once per step.
REQ-032 Frame shadow: data changed to 32'hFFFFFFFF while sel=3 -> digits 3..7 keep old codes; at the next sel=0, seg=38.
REQ-033 Enable hold: en=0 for 10 cycles at sel=5 -> sel stays 5, tick=0, seg unchanged; after en=1, the next advance occurs after the remaining prescaler count.
REQ-034 Short frame: DIGITS=3 -> sel sequence 0,1,2,0,1; blank_mask=8'h02 -> seg=7F while sel=1.
REQ-035 Blanking: data=32'h000000A0 -> with LEADING_ZERO_BLANK_EN, sel 2..7 give 7F, sel=1 gives 08, sel=0 gives 01; without the macro, sel=2 gives 01.
